// File: rtl/range_pkg.sv
// rtl/range_pkg.sv - shared state encoding and default sizing for the echo range meter
package range_pkg;
  localparam int DEFAULT_CLKS_PER_CM = 2940;
  localparam int DEFAULT_MAX_CM      = 400;
  localparam int DEFAULT_WAIT_CLKS   = 1_500_000;
  localparam int BCD_DIGITS          = 3;
  localparam int CM_W                = 9;
  localparam int BCD_W               = 4 * BCD_DIGITS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RISE,
    ST_MEASURE,
    ST_CONVERT,
    ST_DONE
  } state_e;
endpackage

// File: rtl/echo_range_meas_if.sv
// rtl/echo_range_meas_if.sv - trigger/echo inputs and distance result bundle
interface echo_range_meas_if;
  import range_pkg::*;

  logic             meas_start;
  logic             echo_in;
  logic             busy;
  logic             dist_vld;
  logic [CM_W-1:0]  dist_cm;
  logic [BCD_W-1:0] dist_bcd;
  logic             timeout_err;

  modport master (
    output meas_start, echo_in,
    input  busy, dist_vld, dist_cm, dist_bcd, timeout_err
  );

  modport slave (
    input  meas_start, echo_in,
    output busy, dist_vld, dist_cm, dist_bcd, timeout_err
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - iterative double-dabble, one input bit per cycle
// The start cycle already performs the first step, so done rises CM_W cycles after start.
module bin2bcd_seq
  import range_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CM_W-1:0]  bin,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);
  localparam int STEPS = CM_W;
  localparam int CNT_W = $clog2(STEPS + 1);

  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [CM_W-1:0]  sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             act_q, act_d;
  logic             done_q, done_d;

  function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] b, input logic bit_in);
    logic [BCD_W-1:0] adj;
    adj = b;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    return {adj[BCD_W-2:0], bit_in};
  endfunction

  always_comb begin
    bcd_d  = bcd_q;
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    act_d  = act_q;
    done_d = 1'b0;
    if (start) begin
      bcd_d = dabble('0, bin[CM_W-1]);
      sh_d  = {bin[CM_W-2:0], 1'b0};
      cnt_d = CNT_W'(1);
      act_d = 1'b1;
    end else if (act_q) begin
      bcd_d = dabble(bcd_q, sh_q[CM_W-1]);
      sh_d  = {sh_q[CM_W-2:0], 1'b0};
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(STEPS - 1)) begin
        act_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_q  <= '0;
      sh_q   <= '0;
      cnt_q  <= '0;
      act_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      bcd_q  <= bcd_d;
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign bcd  = bcd_q;
endmodule

// File: rtl/echo_range_meas.sv
// rtl/echo_range_meas.sv - times the echo pulse after each trigger and reports whole centimetres
module echo_range_meas
  import range_pkg::*;
#(
  parameter int CLKS_PER_CM = DEFAULT_CLKS_PER_CM,
  parameter int MAX_CM      = DEFAULT_MAX_CM,
  parameter int WAIT_CLKS   = DEFAULT_WAIT_CLKS
) (
  input logic              sys_clk,
  input logic              sys_rst,
  echo_range_meas_if.slave io
);
  localparam int PRE_W  = (CLKS_PER_CM > 1) ? $clog2(CLKS_PER_CM) : 1;
  localparam int WAIT_W = (WAIT_CLKS > 1) ? $clog2(WAIT_CLKS) : 1;

  state_e           state_q, state_d;
  logic [2:0]       sync_q, sync_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CM_W-1:0]  cm_q, cm_d;
  logic             err_q, err_d;
  logic             dist_vld_q, dist_vld_d;
  logic [CM_W-1:0]  dist_cm_q, dist_cm_d;
  logic [BCD_W-1:0] dist_bcd_q, dist_bcd_d;
  logic             timeout_q, timeout_d;

  logic             s2, s3, rise, fall, count_en;
  logic             conv_start, conv_done;
  logic [BCD_W-1:0] conv_bcd;

  // sync_q[1] is the synchronised echo, sync_q[2] its one-cycle-old copy
  assign sync_d = {sync_q[1:0], io.echo_in};
  assign s2     = sync_q[1];
  assign s3     = sync_q[2];
  assign rise   = s2 & ~s3;
  assign fall   = ~s2 & s3;

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    pre_d      = pre_q;
    cm_d       = cm_q;
    err_d      = err_q;
    count_en   = 1'b0;
    conv_start = 1'b0;
    dist_vld_d = 1'b0;
    dist_cm_d  = dist_cm_q;
    dist_bcd_d = dist_bcd_q;
    timeout_d  = timeout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (io.meas_start) begin
          state_d = ST_WAIT_RISE;
          wait_d  = '0;
          pre_d   = '0;
          cm_d    = '0;
          err_d   = 1'b0;
        end
      end
      ST_WAIT_RISE: begin
        // The rise cycle itself is the first echo-high cycle, so it is counted too
        if (rise) begin
          state_d  = ST_MEASURE;
          count_en = 1'b1;
        end else if (wait_q == WAIT_W'(WAIT_CLKS - 1)) begin
          state_d    = ST_CONVERT;
          cm_d       = '0;
          err_d      = 1'b1;
          conv_start = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_MEASURE: begin
        if (fall) begin
          state_d    = ST_CONVERT;
          conv_start = 1'b1;
        end else if (s2) begin
          count_en = 1'b1;
        end
      end
      ST_CONVERT: begin
        if (conv_done) begin
          state_d    = ST_DONE;
          dist_vld_d = 1'b1;
          dist_cm_d  = cm_q;
          dist_bcd_d = conv_bcd;
          timeout_d  = err_q;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (count_en) begin
      if (pre_q == PRE_W'(CLKS_PER_CM - 1)) begin
        pre_d = '0;
        cm_d  = cm_q + CM_W'(1);
        if (cm_q == CM_W'(MAX_CM - 1)) begin
          state_d    = ST_CONVERT;
          err_d      = 1'b1;
          conv_start = 1'b1;
        end
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      sync_q     <= '0;
      wait_q     <= '0;
      pre_q      <= '0;
      cm_q       <= '0;
      err_q      <= 1'b0;
      dist_vld_q <= 1'b0;
      dist_cm_q  <= '0;
      dist_bcd_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      wait_q     <= wait_d;
      pre_q      <= pre_d;
      cm_q       <= cm_d;
      err_q      <= err_d;
      dist_vld_q <= dist_vld_d;
      dist_cm_q  <= dist_cm_d;
      dist_bcd_q <= dist_bcd_d;
      timeout_q  <= timeout_d;
    end
  end

  bin2bcd_seq u_bin2bcd (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .start (conv_start),
    .bin   (cm_d),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  assign io.busy        = (state_q != ST_IDLE);
  assign io.dist_vld    = dist_vld_q;
  assign io.dist_cm     = dist_cm_q;
  assign io.dist_bcd    = dist_bcd_q;
  assign io.timeout_err = timeout_q;
endmodule

// File: tb/tb_echo_range_meas.sv
// tb/tb_echo_range_meas.sv - randomized scoreboard bench for echo_range_meas
module tb_echo_range_meas;
  import range_pkg::*;

  localparam int CPC   = 10;
  localparam int MAXC  = 400;
  localparam int WAITC = 200;

  typedef struct {
    int cyc;
    int cm;
    int bcd;
    int err;
  } rec_t;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  int   cyc     = 0;
  int   n_cmp   = 0;
  int   n_mis   = 0;
  rec_t got_q[$];
  rec_t exp_q[$];
  rec_t mon_r;

  echo_range_meas_if io ();

  echo_range_meas #(
    .CLKS_PER_CM (CPC),
    .MAX_CM      (MAXC),
    .WAIT_CLKS   (WAITC)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .io      (io)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (io.dist_vld) begin
      mon_r.cyc = cyc;
      mon_r.cm  = int'(io.dist_cm);
      mon_r.bcd = int'(io.dist_bcd);
      mon_r.err = int'(io.timeout_err);
      got_q.push_back(mon_r);
    end
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic int bcd_of(input int v);
    return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic push_exp(input int c, input int cm, input int err);
    rec_t r;
    r.cyc = c;
    r.cm  = cm;
    r.bcd = bcd_of(cm);
    r.err = err;
    exp_q.push_back(r);
  endtask

  task automatic pulse_start();
    io.meas_start = 1'b1;
    tick(1);
    io.meas_start = 1'b0;
  endtask

  task automatic settle();
    rec_t e;
    rec_t g;
    check_eq("result_count", got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check_eq("vld_cycle", g.cyc, e.cyc);
      check_eq("dist_cm", g.cm, e.cm);
      check_eq("dist_bcd", g.bcd, e.bcd);
      check_eq("timeout_err", g.err, e.err);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // Reference: echo high W cycles gives W/CPC cm; saturation fires MAXC*CPC cycles
  // after the synchronised rise; a missing echo times out WAITC cycles after start.
  task automatic run_meas(input int gap, input int width, input bit pokes);
    int t0;
    int tr;
    int tf;
    bit over;
    t0 = cyc;
    pulse_start();
    tick(gap - 1);
    if (width == 0) begin
      push_exp(t0 + WAITC + 10, 0, 1);
      tick(WAITC + 20 - gap);
    end else begin
      over = (width / CPC) >= MAXC;
      tr = cyc;
      io.echo_in = 1'b1;
      if (over) push_exp(tr + 2 + MAXC * CPC - 1 + 10, MAXC, 1);
      for (int i = 0; i < width; i++) begin
        io.meas_start = (pokes && !over && (i % 97) == 5);
        tick(1);
      end
      io.meas_start = 1'b0;
      io.echo_in    = 1'b0;
      tf = cyc;
      if (!over) push_exp(tf + 12, width / CPC, 0);
      if (pokes && !over) begin
        tick(5);
        io.meas_start = 1'b1;
        tick(1);
        io.meas_start = 1'b0;
        tick(14);
      end else begin
        tick(20);
      end
    end
    settle();
  endtask

  initial begin
    int tr;
    int t1;
    int gap;
    int sel;
    int width;
    io.meas_start = 1'b0;
    io.echo_in    = 1'b0;
    #1 sys_rst = 1'b1;
    tick(3);
    check_eq("rst_busy", io.busy, 0);
    check_eq("rst_vld", io.dist_vld, 0);
    check_eq("rst_cm", io.dist_cm, 0);
    check_eq("rst_bcd", io.dist_bcd, 0);
    check_eq("rst_err", io.timeout_err, 0);
    sys_rst = 1'b0;
    tick(3);

    run_meas(50, 1234, 1'b0);
    run_meas(5, 9, 1'b0);
    run_meas(5, 10, 1'b0);
    run_meas(5, 19, 1'b0);
    run_meas(5, 0, 1'b0);
    run_meas(10, 345, 1'b1);

    // Over-range, then a restart while the stale echo is still high
    pulse_start();
    tick(2);
    tr = cyc;
    io.echo_in = 1'b1;
    push_exp(tr + 2 + MAXC * CPC - 1 + 10, MAXC, 1);
    tick(MAXC * CPC + 2 + 10 + 5);
    check_eq("over_busy_echo_high", io.busy, 0);
    t1 = cyc;
    pulse_start();
    push_exp(t1 + WAITC + 10, 0, 1);
    tick(WAITC + 20);
    tick(5000 - (cyc - tr));
    io.echo_in = 1'b0;
    tick(20);
    settle();

    // Reset in the middle of a measurement
    pulse_start();
    tick(3);
    io.echo_in = 1'b1;
    tick(300);
    check_eq("pre_rst_busy", io.busy, 1);
    sys_rst = 1'b1;
    #1;
    check_eq("mid_rst_busy", io.busy, 0);
    check_eq("mid_rst_vld", io.dist_vld, 0);
    check_eq("mid_rst_cm", io.dist_cm, 0);
    check_eq("mid_rst_bcd", io.dist_bcd, 0);
    check_eq("mid_rst_err", io.timeout_err, 0);
    tick(3);
    io.echo_in = 1'b0;
    sys_rst = 1'b0;
    tick(20);
    settle();
    run_meas(5, 57, 1'b0);

    for (int k = 0; k < 10; k++) begin
      gap = $urandom_range(2, 60);
      sel = $urandom_range(0, 9);
      if (sel == 0) width = 0;
      else if (sel == 1) width = $urandom_range(3995, 4300);
      else width = $urandom_range(1, 800);
      run_meas(gap, width, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/echo_range_meas.md
Name: echo_range_meas

Overview:
- Downstream consumer of the ultrasonic trigger/echo front end.
- After each trigger burst, times the sensor echo pulse and converts its width to whole centimetres, saturating at MAX_CM.
- Outputs the distance as binary and as 3-digit BCD with a one-cycle valid strobe, ready for the LED/7-segment display driver.
- Flags missing or over-range echoes.

Parameters:
- CLKS_PER_CM, 2940: sys_clk cycles per 1 cm of range (58.8 us round trip at 50 MHz).
- MAX_CM, 400: saturation distance; must be ≤ 511.
- WAIT_CLKS, 1_500_000: maximum wait from meas_start to the echo rising edge (30 ms).

Ports:
- sys_clk, input, 1: system clock.
- sys_rst, input, 1: asynchronous active-high reset.
- meas_start, input, 1: one-cycle pulse at the end of the trigger burst.
- echo_in, input, 1: raw asynchronous echo from the sensor.
- busy, output, 1: high in every state except IDLE.
- dist_vld, output, 1: one-cycle strobe; dist_cm, dist_bcd and timeout_err are valid when it is high.
- dist_cm, output, 9: distance in cm, binary.
- dist_bcd, output, 12: hundreds[11:8], tens[7:4], units[3:0].
- timeout_err, output, 1: last result was a no-echo or over-range result.

Behaviour:
- Clock and reset: one clock (sys_clk). sys_rst is asynchronous, active-high.
- Reset values: all outputs 0, FSM in IDLE, all counters 0.
- Reset mid-operation aborts immediately. No dist_vld is issued for the aborted measurement.
- Echo synchronisation:
  - echo_in passes through a 2-FF synchroniser, then a third register for edge detection.
  - rise = s2 & ~s3; fall = ~s2 & s3.
- FSM states: IDLE, WAIT_RISE, MEASURE, CONVERT, DONE.
- IDLE:
  - meas_start=1 → WAIT_RISE; clear wait_cnt, pre_cnt and cm_cnt.
  - meas_start in any other state is ignored. No queueing.
- WAIT_RISE:
  - rise → MEASURE.
  - wait_cnt == WAIT_CLKS-1 with no rise → CONVERT with cm_cnt=0 and err=1.
  - rise wins if both occur in the same cycle.
- MEASURE (each cycle while s2=1):
  - pre_cnt increments.
  - When pre_cnt == CLKS_PER_CM-1: pre_cnt wraps to 0 and cm_cnt increments.
  - Result is truncated: partial centimetres are dropped.
- MEASURE exits:
  - fall → CONVERT. A wrap in the fall cycle is not counted.
  - cm_cnt reaching MAX_CM → CONVERT immediately with cm_cnt=MAX_CM and err=1. Do not wait for the fall edge.
  - Any echo remainder after exit is ignored. The next measurement requires a fresh rise after meas_start.
- CONVERT: sequential double-dabble of cm_cnt (9 bits → 12-bit BCD).
  - Exactly 9 cycles.
  - Each cycle: add 3 to any BCD nibble ≥ 5, then shift left one bit.
- DONE, one cycle:
  - dist_vld=1.
  - dist_cm, dist_bcd and timeout_err are registered and held until the next DONE.
  - Then → IDLE.
- Latency:
  - Fall detected in cycle N → dist_vld in cycle N+10.
  - echo_in to rise/fall detection adds 2 cycles of synchroniser delay.
- Widths:
  - pre_cnt: clog2(CLKS_PER_CM).
  - wait_cnt: clog2(WAIT_CLKS).
  - cm_cnt: 9 bits, never exceeds MAX_CM.
- Echo already high at meas_start: no rise is seen, so the result is WAIT timeout. This is intentional; it rejects stale echoes.

Decomposition:
- Shared package (range_pkg): FSM state encoding, DEFAULT_CLKS_PER_CM, DEFAULT_MAX_CM, BCD_DIGITS=3.
- One sub-module, bin2bcd_seq: start/done handshake, 9-bit in, 12-bit out, 9-cycle iterative double-dabble. It is reusable by the display driver.
- Synchroniser and edge detect stay inline.

Test Plan (CLKS_PER_CM=10, MAX_CM=400, WAIT_CLKS=200 unless stated):
- Nominal: meas_start, echo_in high for 1234 cycles after 50 cycles → dist_vld once, dist_cm=123, dist_bcd=0x123, timeout_err=0, 10 cycles after fall detection.
- Truncation: echo widths 9, 10 and 19 cycles → dist_cm 0, 1, 1.
- No echo: meas_start with echo_in held low → dist_vld at cycle ~200+10, dist_cm=0, timeout_err=1.
- Over-range: echo high for 5000 cycles → dist_vld before echo falls, dist_cm=400, dist_bcd=0x400, timeout_err=1.
  - A second meas_start while echo is still high → no rise, result is WAIT timeout.
- meas_start pulsed while busy → ignored; exactly one dist_vld per accepted start.
- Reset mid-MEASURE: sys_rst asserted for 3 cycles → all outputs 0, busy=0, no dist_vld.
  - A following normal measurement of 57 cycles → dist_cm=5, dist_bcd=0x005.
